// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// One transaction in flight; a watchdog aborts accesses that never see mem_ready.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic                          mem_read_enable,
    output logic                          mem_write_enable,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    input  logic                          mem_ready
);

    typedef enum logic [1:0] {ARB, ACCESS, RELEASE} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [2:0]              ptr;
    logic [2:0]              ptr_d;
    logic [2:0]              ptr_next;
    logic [15:0]             watchdog;
    logic [15:0]             wd_d;
    logic                    wd_expired;

    logic                    found;
    logic [2:0]              win;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_we;

    logic [NUM_REQ-1:0]      done_d;
    logic [NUM_REQ-1:0]      err_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [2:0]              grant_d;
    logic                    busy_d;
    logic                    re_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;

    assign wd_expired = (watchdog == 16'(TIMEOUT - 1));
    assign ptr_next   = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

    // Round-robin scan: first valid requester at or above ptr, wrapping.
    // The outer loop walks scan order so the earliest hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req_valid[j] && (((32'(ptr) + i) % NUM_REQ) == j)) begin
                    found = 1'b1;
                    win   = 3'(j);
                end
            end
        end
    end

    // Select the winning requester's address, data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win == 3'(j)) begin
                sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = req_we[j];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; mem_ready takes priority over the watchdog.
    always_comb begin
        next_state = state;
        unique case (state)
            ARB:     if (found) next_state = ACCESS;
            ACCESS:  if (mem_ready || wd_expired) next_state = RELEASE;
            RELEASE: next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    // Next values for every registered output, pointer and watchdog.
    always_comb begin
        done_d  = '0;
        err_d   = '0;
        rdata_d = rsp_rdata;
        grant_d = grant_id;
        busy_d  = busy;
        re_d    = mem_read_enable;
        we_d    = mem_write_enable;
        addr_d  = mem_address;
        wdata_d = mem_write_data;
        ptr_d   = ptr;
        wd_d    = watchdog;
        unique case (state)
            ARB: begin
                re_d   = 1'b0;
                we_d   = 1'b0;
                busy_d = 1'b0;
                if (found) begin
                    grant_d = win;
                    busy_d  = 1'b1;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    re_d    = ~sel_we;
                    we_d    = sel_we;
                    wd_d    = '0;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (mem_read_enable) rdata_d = mem_read_data;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (grant_id == 3'(i)) done_d[i] = 1'b1;
                    end
                    re_d  = 1'b0;
                    we_d  = 1'b0;
                    ptr_d = ptr_next;
                end else if (wd_expired) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (grant_id == 3'(i)) err_d[i] = 1'b1;
                    end
                    re_d  = 1'b0;
                    we_d  = 1'b0;
                    ptr_d = ptr_next;
                end else begin
                    wd_d = watchdog + 16'd1;
                end
            end
            RELEASE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output, pointer and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_done         <= '0;
            req_err          <= '0;
            rsp_rdata        <= '0;
            grant_id         <= '0;
            busy             <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            ptr              <= '0;
            watchdog         <= '0;
        end else begin
            req_done         <= done_d;
            req_err          <= err_d;
            rsp_rdata        <= rdata_d;
            grant_id         <= grant_d;
            busy             <= busy_d;
            mem_read_enable  <= re_d;
            mem_write_enable <= we_d;
            mem_address      <= addr_d;
            mem_write_data   <= wdata_d;
            ptr              <= ptr_d;
            watchdog         <= wd_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions are queued as
// requests are driven, and a monitor pops them at grant and completion.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int TO = 10;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [DW-1:0]     rsp_rdata;
    logic [2:0]        grant_id;
    logic              busy;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_write_data;
    logic [DW-1:0]     mem_read_data;
    logic              mem_ready;

    mem_port_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_done        (req_done),
        .req_err         (req_err),
        .rsp_rdata       (rsp_rdata),
        .grant_id        (grant_id),
        .busy            (busy),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;

    // ---------------- memory model ----------------
    logic [63:0] mem [logic [15:0]];
    int          mem_lat  = 1;
    bit          mem_hang = 1'b0;
    int          mem_cnt  = 0;

    always @(negedge clk) begin
        if (reset) begin
            mem_cnt       = 0;
            mem_ready     = 1'b0;
            mem_read_data = '0;
        end else if (mem_read_enable || mem_write_enable) begin
            mem_cnt = mem_cnt + 1;
            if (!mem_hang && mem_cnt == mem_lat) begin
                mem_ready = 1'b1;
                if (mem_write_enable) begin
                    mem[mem_address] = mem_write_data;
                    mem_read_data    = ~mem_write_data;
                end else begin
                    mem_read_data = mem.exists(mem_address) ? mem[mem_address] : 64'h0;
                end
            end else begin
                mem_ready     = 1'b0;
                mem_read_data = 64'h0BAD_0BAD_0BAD_0BAD;
            end
        end else begin
            mem_cnt       = 0;
            mem_ready     = 1'b0;
            mem_read_data = 64'h0BAD_0BAD_0BAD_0BAD;
        end
    end

    // ---------------- scoreboard monitor ----------------
    exp_t        cur;
    bit          have_cur   = 1'b0;
    bit          prev_en    = 1'b0;
    bit          prev_pulse = 1'b0;
    int          en_cycles  = 0;
    logic [63:0] last_rd    = '0;

    always @(posedge clk) begin
        logic       en;
        logic       pulse;
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        #1;
        if (reset) begin
            have_cur   = 1'b0;
            prev_en    = 1'b0;
            prev_pulse = 1'b0;
            en_cycles  = 0;
            last_rd    = '0;
        end else begin
            en    = mem_read_enable | mem_write_enable;
            pulse = (|req_done) | (|req_err);
            if (en && !prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got grant_id %0d, want no grant", grant_id);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    checks++;
                    if (grant_id !== 3'(cur.id)) begin
                        errors++;
                        $display("FAIL grant_id: got %0d want %0d", grant_id, cur.id);
                    end
                    checks++;
                    if ({mem_write_enable, mem_read_enable} !== (cur.we ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL enables: got we=%0b re=%0b want we=%0b", mem_write_enable, mem_read_enable, cur.we);
                    end
                    checks++;
                    if (mem_address !== cur.addr) begin
                        errors++;
                        $display("FAIL mem_address: got %h want %h", mem_address, cur.addr);
                    end
                    if (cur.we) begin
                        checks++;
                        if (mem_write_data !== cur.wdata) begin
                            errors++;
                            $display("FAIL mem_write_data: got %h want %h", mem_write_data, cur.wdata);
                        end
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_access: got %0b want 1", busy);
                    end
                end
                en_cycles = 0;
            end
            if (en) en_cycles++;
            if (prev_pulse) begin
                checks++;
                if (en) begin
                    errors++;
                    $display("FAIL release_gap: got enables high after pulse, want low");
                end
            end
            if (pulse) begin
                ev_cnt++;
                checks++;
                if (!have_cur) begin
                    errors++;
                    $display("FAIL spurious_pulse: got done=%b err=%b want none", req_done, req_err);
                end else begin
                    exp_done = cur.err ? 4'b0000 : (4'b0001 << cur.id);
                    exp_err  = cur.err ? (4'b0001 << cur.id) : 4'b0000;
                    checks++;
                    if (req_done !== exp_done) begin
                        errors++;
                        $display("FAIL req_done: got %b want %b", req_done, exp_done);
                    end
                    checks++;
                    if (req_err !== exp_err) begin
                        errors++;
                        $display("FAIL req_err: got %b want %b", req_err, exp_err);
                    end
                    checks++;
                    if (en_cycles != cur.cycles) begin
                        errors++;
                        $display("FAIL access_cycles: got %0d want %0d", en_cycles, cur.cycles);
                    end
                    if (!cur.err) begin
                        if (!cur.we) last_rd = cur.rdata;
                        checks++;
                        if (rsp_rdata !== last_rd) begin
                            errors++;
                            $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, last_rd);
                        end
                    end
                    checks++;
                    if (en || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL release_state: got en=%0b busy=%0b want en=0 busy=1", en, busy);
                    end
                    have_cur = 1'b0;
                end
            end
            prev_en    = en;
            prev_pulse = pulse;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input bit we, input logic [15:0] a, input logic [63:0] d);
        req_we[id]            = we;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    task automatic push_exp(input int id, input bit we, input logic [15:0] a, input logic [63:0] wd,
                            input logic [63:0] rd, input bit err, input int cyc);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = err; e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_events(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ev_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i * 32'h0101_0101);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_done, req_err, rsp_rdata, grant_id, busy, mem_read_enable, mem_write_enable,
             mem_address, mem_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b re=%0b we=%0b addr=%h want all zero",
                     busy, mem_read_enable, mem_write_enable, mem_address);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_read_enable, mem_write_enable} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got busy/re/we %b want 000", {busy, mem_read_enable, mem_write_enable});
        end
    endtask

    task automatic test_single_read();
        bit ok;
        int base;
        mem[16'h0040] = 64'hDEADBEEF_00000001;
        mem_lat = 1;
        base = ev_cnt;
        set_req(2, 1'b0, 16'h0040, '0);
        push_exp(2, 1'b0, 16'h0040, '0, 64'hDEADBEEF_00000001, 1'b0, 1);
        req_valid = 4'b0100;
        wait_events(base + 1, 50, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_read_timeout: got no completion want 1"); end
        checks++;
        if (grant_id !== 3'd2) begin errors++; $display("FAIL single_read_grant: got %0d want 2", grant_id); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        mem_lat = 2;
        base = ev_cnt;
        set_req(1, 1'b1, 16'h0100, 64'h1122334455667788);
        push_exp(1, 1'b1, 16'h0100, 64'h1122334455667788, '0, 1'b0, 2);
        push_exp(1, 1'b0, 16'h0100, '0, 64'h1122334455667788, 1'b0, 2);
        req_valid = 4'b0010;
        wait_events(base + 1, 50, ok);
        set_req(1, 1'b0, 16'h0100, '0);
        wait_events(base + 2, 50, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL back_to_back_timeout: got %0d events want %0d", ev_cnt - base, 2); end
    endtask

    task automatic test_contention();
        bit ok;
        int base;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < NR; i++) begin
            mem[16'(16'h0200 + i * 8)] = pat(i);
            set_req(i, 1'b0, 16'(16'h0200 + i * 8), '0);
        end
        for (int k = 0; k < 8; k++)
            push_exp(k % NR, 1'b0, 16'(16'h0200 + (k % NR) * 8), '0, pat(k % NR), 1'b0, 3);
        base = ev_cnt;
        req_valid = 4'b1111;
        wait_events(base + 8, 200, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_timeout: got %0d events want 8", ev_cnt - base); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL contention_queue: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        int base;
        mem_lat = 1;
        base = ev_cnt;
        // last grant was 3: pointer wrapped to 0, so 0 precedes 2
        push_exp(0, 1'b0, 16'h0200, '0, pat(0), 1'b0, 1);
        push_exp(2, 1'b0, 16'h0210, '0, pat(2), 1'b0, 1);
        req_valid = 4'b0101;
        wait_events(base + 1, 50, ok);
        req_valid[0] = 1'b0;
        wait_events(base + 2, 50, ok);
        req_valid = '0;
        // grant 1 alone leaves pointer at 2, so 2 now precedes 0
        push_exp(1, 1'b0, 16'h0208, '0, pat(1), 1'b0, 1);
        req_valid = 4'b0010;
        wait_events(base + 3, 50, ok);
        req_valid = '0;
        push_exp(2, 1'b0, 16'h0210, '0, pat(2), 1'b0, 1);
        push_exp(0, 1'b0, 16'h0200, '0, pat(0), 1'b0, 1);
        req_valid = 4'b0101;
        wait_events(base + 4, 50, ok);
        req_valid[2] = 1'b0;
        wait_events(base + 5, 50, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d events want 5", ev_cnt - base); end
    endtask

    task automatic test_timeout();
        bit ok;
        int base;
        do_reset();
        mem[16'h0308] = 64'h0F0F_1234_5678_9ABC;
        mem[16'h0310] = 64'h7777_6666_5555_4444;
        mem_hang = 1'b1;
        base = ev_cnt;
        set_req(0, 1'b0, 16'h0300, '0);
        set_req(1, 1'b0, 16'h0308, '0);
        push_exp(0, 1'b0, 16'h0300, '0, '0, 1'b1, TO);
        push_exp(1, 1'b0, 16'h0308, '0, 64'h0F0F_1234_5678_9ABC, 1'b0, 1);
        req_valid = 4'b0011;
        wait_events(base + 1, 60, ok);
        mem_hang = 1'b0;
        mem_lat = 1;
        req_valid[0] = 1'b0;
        wait_events(base + 2, 60, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_recover: got %0d events want 2", ev_cnt - base); end
        // ready on exactly the last watchdog cycle completes normally
        mem_lat = TO;
        set_req(2, 1'b0, 16'h0310, '0);
        push_exp(2, 1'b0, 16'h0310, '0, 64'h7777_6666_5555_4444, 1'b0, TO);
        req_valid = 4'b0100;
        wait_events(base + 3, 60, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_boundary: got %0d events want 3", ev_cnt - base); end
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        int base;
        mem[16'h0318] = 64'hCAFE_F00D_0000_0003;
        mem_hang = 1'b1;
        set_req(3, 1'b0, 16'h0318, '0);
        push_exp(3, 1'b0, 16'h0318, '0, '0, 1'b0, 0);
        req_valid = 4'b1000;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_read_enable) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_grant: got re=0 want 1"); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read_enable, mem_write_enable, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_enables: got re/we/busy %b want 000", {mem_read_enable, mem_write_enable, busy});
        end
        checks++;
        if ({grant_id, mem_address, rsp_rdata, req_done, req_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_regs: got grant=%0d addr=%h rdata=%h want zero", grant_id, mem_address, rsp_rdata);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_hang = 1'b0;
        mem_lat = 2;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_queue: got %0d want 0", exp_q.size()); end
        exp_q.delete();
        base = ev_cnt;
        push_exp(3, 1'b0, 16'h0318, '0, 64'hCAFE_F00D_0000_0003, 1'b0, 2);
        req_valid = 4'b1000;
        wait_events(base + 1, 50, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_retry: got no completion want 1"); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_pointer_wrap();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "time limit");
    end

endmodule
